mips_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the CPU memory bus (read/write/waitrequest/byteenable handshake), placed between requesters and the single cpu_ram slave.
- Typical use: master 0 is the CPU; master 1 is a loader/DMA/debug port that shares the RAM.
- Holds a grant for exactly one transfer, then re-arbitrates using round-robin or fixed priority.

---
 rtl/mips_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave arbiter for the CPU memory bus; the grant is held for exactly one transfer.
// Latency: the slave strobe appears 1 cycle after a request, and a zero-wait transfer takes 2 cycles.
// Backpressure: the owner sees s_waitrequest, and the non-owner is held with waitrequest = 1.
module mips_bus_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,

    output logic        busy,
    output logic        owner
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;

    logic        req0, req1;
    logic        winner;
    logic        own_req;
    logic        own_read, own_write;
    logic [31:0] own_address, own_writedata;
    logic [3:0]  own_byteenable;

    // Owner's view of the bus; a simultaneous read+write is treated as a write.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;

        if (owner_q) begin
            own_read       = m1_read & ~m1_write;
            own_write      = m1_write;
            own_address    = m1_address;
            own_writedata  = m1_writedata;
            own_byteenable = m1_byteenable;
            own_req        = req1;
        end else begin
            own_read       = m0_read & ~m0_write;
            own_write      = m0_write;
            own_address    = m0_address;
            own_writedata  = m0_writedata;
            own_byteenable = m0_byteenable;
            own_req        = req0;
        end
    end

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            if (FIXED_PRIORITY != 0) begin
                winner = 1'b0;
            end else begin
                winner = ~last_owner_q;
            end
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_BUSY;
                    owner_d = winner;
                end
            end
            ST_BUSY: begin
                // A request dropped mid-transfer is abandoned without counting as a turn.
                if (!own_req) begin
                    state_d = ST_IDLE;
                end else if (!s_waitrequest) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_address      = 32'h0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = 32'h0;
        s_byteenable   = 4'h0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        if (state_q == ST_BUSY) begin
            s_address    = own_address;
            s_read       = own_read;
            s_write      = own_write;
            s_writedata  = own_writedata;
            s_byteenable = own_byteenable;
            if (owner_q) begin
                m1_waitrequest = s_waitrequest;
            end else begin
                m0_waitrequest = s_waitrequest;
            end
        end
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign busy        = (state_q == ST_BUSY);
    assign owner       = owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench: a round-robin arbiter in front of a small RAM model, plus a fixed-priority
// instance that shares the same master stimulus and sits on an always-ready slave.
module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;

    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic        busy, owner;

    logic        fp_m0_waitrequest, fp_m1_waitrequest;
    logic [31:0] fp_m0_readdata, fp_m1_readdata;
    logic [31:0] fp_s_address, fp_s_writedata;
    logic        fp_s_read, fp_s_write;
    logic [3:0]  fp_s_byteenable;
    logic        fp_busy, fp_owner;
    logic        fp_s_waitrequest;
    logic [31:0] fp_s_readdata;

    logic [31:0] mem [0:255];

    int total;
    int bad;

    mips_bus_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .busy(busy), .owner(owner)
    );

    mips_bus_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_writedata(fp_s_writedata), .s_byteenable(fp_s_byteenable),
        .s_waitrequest(fp_s_waitrequest), .s_readdata(fp_s_readdata),
        .busy(fp_busy), .owner(fp_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fp_s_waitrequest = 1'b0;
    assign fp_s_readdata    = 32'h0;

    assign s_readdata = mem[s_address[9:2]];

    always @(posedge clk) begin
        if (s_write && !s_waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteenable[b]) mem[s_address[9:2]][8*b +: 8] <= s_writedata[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0;
        m0_writedata = 32'h0; m0_byteenable = 4'h0;
        m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0;
        m1_writedata = 32'h0; m1_byteenable = 4'h0;
    endtask

    task automatic do_reset();
        clear_masters();
        s_waitrequest = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_masters();
        s_waitrequest = 1'b0;
        m0_address = 32'hBFC0_0000;
        m0_read    = 1'b1;
        reset      = 1'b1;
        tick();
        tick();
        total++; if (s_read !== 1'b0) begin bad++; $display("FAIL reset_s_read: got %b want 0", s_read); end
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL post_reset_busy: got %b want 1", busy); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL post_reset_owner: got %b want 0", owner); end
        total++; if (s_address !== 32'hBFC0_0000) begin bad++; $display("FAIL post_reset_addr: got %h want bfc00000", s_address); end
        total++; if (s_read !== 1'b1) begin bad++; $display("FAIL post_reset_s_read: got %b want 1", s_read); end
        tick();
        clear_masters();
    endtask

    task automatic test_single_read();
        do_reset();
        mem[16] = 32'h1234_5678;
        m0_address = 32'h0000_0040;
        m0_read    = 1'b1;
        #1;
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL single_wait_c1: got %b want 1", m0_waitrequest); end
        tick();
        total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL single_wait_c2: got %b want 0", m0_waitrequest); end
        total++; if (m0_readdata !== 32'h1234_5678) begin bad++; $display("FAIL single_rdata: got %h want 12345678", m0_readdata); end
        total++; if (s_read !== 1'b1) begin bad++; $display("FAIL single_s_read: got %b want 1", s_read); end
        tick();
        clear_masters();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
        total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL single_wait_end: got %b want 1", m0_waitrequest); end
    endtask

    task automatic test_contention();
        do_reset();
        mem[64]  = 32'h0;
        mem[128] = 32'hCAFE_F00D;
        m0_address = 32'h0000_0100; m0_write = 1'b1;
        m0_writedata = 32'hAABB_CCDD; m0_byteenable = 4'hF;
        m1_address = 32'h0000_0200; m1_read = 1'b1; m1_byteenable = 4'hF;
        tick();
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL cont_first_owner: got %b want 0", owner); end
        total++; if (s_write !== 1'b1 || s_read !== 1'b0) begin bad++; $display("FAIL cont_s_wr: got w=%b r=%b want w=1 r=0", s_write, s_read); end
        total++; if (s_address !== 32'h0000_0100) begin bad++; $display("FAIL cont_s_addr: got %h want 00000100", s_address); end
        total++; if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL cont_m1_wait_a: got %b want 1", m1_waitrequest); end
        total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL cont_m0_wait: got %b want 0", m0_waitrequest); end
        tick();
        m0_write = 1'b0;
        #1;
        total++; if (mem[64] !== 32'hAABB_CCDD) begin bad++; $display("FAIL cont_ram_word: got %h want aabbccdd", mem[64]); end
        total++; if (busy !== 1'b0 || m1_waitrequest !== 1'b1) begin bad++; $display("FAIL cont_gap: got busy=%b m1w=%b want 0 1", busy, m1_waitrequest); end
        tick();
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL cont_second_owner: got %b want 1", owner); end
        total++; if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin bad++; $display("FAIL cont_m1_grant: got m1w=%b m0w=%b want 0 1", m1_waitrequest, m0_waitrequest); end
        total++; if (m1_readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL cont_m1_rdata: got %h want cafef00d", m1_readdata); end
        tick();
        clear_masters();
    endtask

    task automatic test_stall();
        do_reset();
        mem[16] = 32'h1234_5678;
        m0_address = 32'h0000_0040; m0_read = 1'b1; m0_byteenable = 4'hF;
        m1_address = 32'h0000_0200; m1_read = 1'b1;
        s_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || busy !== 1'b1 ||
                s_read !== 1'b1 || s_address !== 32'h0000_0040 || s_byteenable !== 4'hF) begin
                bad++;
                $display("FAIL stall_cycle%0d: got m0w=%b m1w=%b busy=%b rd=%b addr=%h be=%h want 1 1 1 1 00000040 f",
                         i, m0_waitrequest, m1_waitrequest, busy, s_read, s_address, s_byteenable);
            end
            tick();
        end
        s_waitrequest = 1'b0;
        #1;
        total++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h1234_5678) begin bad++; $display("FAIL stall_complete: got m0w=%b rdata=%h want 0 12345678", m0_waitrequest, m0_readdata); end
        total++; if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL stall_m1_held: got %b want 1", m1_waitrequest); end
        tick();
        m0_read = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy_end: got %b want 0", busy); end
        tick();
        total++; if (owner !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL stall_next_owner: got owner=%b busy=%b want 1 1", owner, busy); end
        tick();
        clear_masters();
    endtask

    task automatic test_priority();
        int exp_busy;
        int exp_owner;
        do_reset();
        m0_address = 32'h0000_0040; m0_read = 1'b1;
        m1_address = 32'h0000_0200; m1_read = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_busy  = i % 2;
            exp_owner = ((i - 1) / 2) % 2;
            total++; if (busy !== exp_busy[0]) begin bad++; $display("FAIL rr_busy_t%0d: got %b want %0d", i, busy, exp_busy); end
            if (exp_busy == 1) begin
                total++; if (owner !== exp_owner[0]) begin bad++; $display("FAIL rr_owner_t%0d: got %b want %0d", i, owner, exp_owner); end
                total++; if (fp_owner !== 1'b0 || fp_busy !== 1'b1) begin bad++; $display("FAIL fp_owner_t%0d: got owner=%b busy=%b want 0 1", i, fp_owner, fp_busy); end
            end
            total++; if (fp_m1_waitrequest !== 1'b1) begin bad++; $display("FAIL fp_m1_wait_t%0d: got %b want 1", i, fp_m1_waitrequest); end
        end
        clear_masters();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem[192] = 32'h0BAD_0BAD;
        m1_address = 32'h0000_0300; m1_write = 1'b1;
        m1_writedata = 32'h5566_7788; m1_byteenable = 4'hF;
        s_waitrequest = 1'b1;
        tick();
        total++; if (owner !== 1'b1 || s_write !== 1'b1) begin bad++; $display("FAIL mid_grant: got owner=%b s_write=%b want 1 1", owner, s_write); end
        reset = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || s_write !== 1'b0 || owner !== 1'b0) begin bad++; $display("FAIL mid_abort: got busy=%b s_write=%b owner=%b want 0 0 0", busy, s_write, owner); end
        reset = 1'b0;
        s_waitrequest = 1'b0;
        m0_address = 32'h0000_0040; m0_read = 1'b1;
        tick();
        total++; if (owner !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mid_first_contention: got owner=%b busy=%b want 0 1", owner, busy); end
        total++; if (mem[192] !== 32'h0BAD_0BAD) begin bad++; $display("FAIL mid_no_write: got %h want 0bad0bad", mem[192]); end
        tick();
        clear_masters();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        s_waitrequest = 1'b0;
        clear_masters();
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
